// File: rtl/alu_result_stage.sv
// alu_result_stage: registers the signed adder result together with its
// destination tag, derives {Z,N,V} flags at capture time, and buffers up to
// two entries in a skid FIFO. It also keeps an overflow sticky bit and a
// saturating overflow counter.
//
// Handshake: a transfer happens on a rising clk edge only when valid and
// ready are both 1 at that edge. The producer holds S/Overflow/Rd steady
// while InValid=1 and InReady=0. InReady and OutValid come only from
// registered occupancy, so neither depends on InValid or OutReady in the
// same cycle. Head data (Result/Flags/OutRd) does not change while
// OutValid=1 and OutReady=0.
module alu_result_stage #(
  parameter int L  = 16,
  parameter int TW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [L-1:0]  S,
  input  logic          Overflow,
  input  logic [TW-1:0] Rd,
  input  logic          InValid,
  output logic          InReady,
  output logic [L-1:0]  Result,
  output logic [2:0]    Flags,
  output logic [TW-1:0] OutRd,
  output logic          OutValid,
  input  logic          OutReady,
  input  logic          ClrSticky,
  output logic          OvfSticky,
  output logic [7:0]    OvfCount
);

  // Occupancy of the two-entry buffer. The encoding is the entry count.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_t;

  occ_t occ;
  occ_t occ_next;

  logic          accept;
  logic          pop;
  logic          load_head;
  logic          load_tail;
  logic          shift;
  logic [2:0]    cap_flags;

  logic [L-1:0]  head_res;
  logic [2:0]    head_flags;
  logic [TW-1:0] head_rd;
  logic [L-1:0]  tail_res;
  logic [2:0]    tail_flags;
  logic [TW-1:0] tail_rd;

  // Both ready and valid depend only on the occupancy register.
  assign InReady  = (occ != OCC_FULL);
  assign OutValid = (occ != OCC_EMPTY);

  assign accept = InValid & InReady;
  assign pop    = OutValid & OutReady;

  // Flags are {Z,N,V} of the incoming sum, with Z at bit 2.
  assign cap_flags = {(S == '0), S[L-1], Overflow};

  // The head register drives the outputs directly, so they hold while stalled.
  assign Result = head_res;
  assign Flags  = head_flags;
  assign OutRd  = head_rd;

  // Occupancy state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ <= OCC_EMPTY;
    end else begin
      occ <= occ_next;
    end
  end

  // Next occupancy and the datapath load and shift controls.
  always_comb begin
    occ_next  = occ;
    load_head = 1'b0;
    load_tail = 1'b0;
    shift     = 1'b0;
    case (occ)
      OCC_EMPTY: begin
        // Nothing to pop here, so OutReady has no effect.
        if (accept) begin
          load_head = 1'b1;
          occ_next  = OCC_ONE;
        end
      end
      OCC_ONE: begin
        if (accept && pop) begin
          // The head leaves and the new entry takes its place.
          load_head = 1'b1;
          occ_next  = OCC_ONE;
        end else if (accept) begin
          load_tail = 1'b1;
          occ_next  = OCC_FULL;
        end else if (pop) begin
          occ_next  = OCC_EMPTY;
        end
      end
      OCC_FULL: begin
        // InReady is 0 here, so only a pop can happen.
        if (pop) begin
          shift    = 1'b1;
          occ_next = OCC_ONE;
        end
      end
      default: begin
        occ_next = OCC_EMPTY;
      end
    endcase
  end

  // Head entry: load from the input, or take the tail when the head pops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_res   <= '0;
      head_flags <= '0;
      head_rd    <= '0;
    end else if (load_head) begin
      head_res   <= S;
      head_flags <= cap_flags;
      head_rd    <= Rd;
    end else if (shift) begin
      head_res   <= tail_res;
      head_flags <= tail_flags;
      head_rd    <= tail_rd;
    end
  end

  // Tail entry: filled only when an accept arrives behind a stalled head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tail_res   <= '0;
      tail_flags <= '0;
      tail_rd    <= '0;
    end else if (load_tail) begin
      tail_res   <= S;
      tail_flags <= cap_flags;
      tail_rd    <= Rd;
    end
  end

  // Overflow tracking. A clear in the same cycle as an accepted V=1 entry
  // leaves the count at 1, because the entry counts after the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      OvfSticky <= 1'b0;
      OvfCount  <= 8'd0;
    end else if (ClrSticky) begin
      OvfSticky <= accept & Overflow;
      OvfCount  <= (accept & Overflow) ? 8'd1 : 8'd0;
    end else if (accept && Overflow) begin
      OvfSticky <= 1'b1;
      if (OvfCount != 8'hFF) begin
        OvfCount <= OvfCount + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage. Inputs change on the falling edge.
// A drain monitor keeps an expected queue of {Result,Flags,OutRd}. It checks
// every popped entry against that queue, in acceptance order.
module tb_alu_result_stage;

  localparam int L  = 16;
  localparam int TW = 3;
  localparam int EW = L + 3 + TW;

  logic          clk;
  logic          rst_n;
  logic [L-1:0]  S;
  logic          Overflow;
  logic [TW-1:0] Rd;
  logic          InValid;
  logic          InReady;
  logic [L-1:0]  Result;
  logic [2:0]    Flags;
  logic [TW-1:0] OutRd;
  logic          OutValid;
  logic          OutReady;
  logic          ClrSticky;
  logic          OvfSticky;
  logic [7:0]    OvfCount;

  // Flags expected for the entry now being driven. The value is hand-computed.
  logic [2:0]    exp_fl;

  logic [EW-1:0] exp_q[$];
  int vectors;
  int miscompares;

  alu_result_stage #(.L(L), .TW(TW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .S         (S),
    .Overflow  (Overflow),
    .Rd        (Rd),
    .InValid   (InValid),
    .InReady   (InReady),
    .Result    (Result),
    .Flags     (Flags),
    .OutRd     (OutRd),
    .OutValid  (OutValid),
    .OutReady  (OutReady),
    .ClrSticky (ClrSticky),
    .OvfSticky (OvfSticky),
    .OvfCount  (OvfCount)
  );

  // Clock generation.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive(input logic [L-1:0] s, input logic ovf, input logic [TW-1:0] rd,
                       input logic [2:0] fl);
    S        = s;
    Overflow = ovf;
    Rd       = rd;
    exp_fl   = fl;
    InValid  = 1'b1;
  endtask

  task automatic idle();
    InValid  = 1'b0;
    S        = '0;
    Overflow = 1'b0;
    Rd       = '0;
    exp_fl   = 3'b000;
  endtask

  // Drain monitor. It samples mid-low-phase, when the inputs are stable
  // before the next rising edge.
  always @(negedge clk) begin
    #2;
    if (rst_n) begin
      if (InValid && InReady) exp_q.push_back({S, exp_fl, Rd});
      if (OutValid && OutReady) begin
        if (exp_q.size() == 0) check("spurious_pop", 32'd1, 32'd0);
        else check("drain_entry", 32'({Result, Flags, OutRd}), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    OutReady    = 1'b0;
    ClrSticky   = 1'b0;
    idle();

    // Reset values.
    #1;
    check("rst_inready", 32'(InReady), 32'd1);
    check("rst_outvalid", 32'(OutValid), 32'd0);
    check("rst_result", 32'(Result), 32'd0);
    check("rst_flags", 32'(Flags), 32'd0);
    check("rst_outrd", 32'(OutRd), 32'd0);
    check("rst_sticky", 32'(OvfSticky), 32'd0);
    check("rst_count", 32'(OvfCount), 32'd0);
    tick();
    tick();

    // Scenario 1: the first accept lands on the first edge after release.
    rst_n    = 1'b1;
    OutReady = 1'b1;
    drive(16'h8000, 1'b1, 3'd5, 3'b011);
    tick();
    check("s1_outvalid", 32'(OutValid), 32'd1);
    check("s1_result", 32'(Result), 32'h8000);
    check("s1_flags", 32'(Flags), 32'b011);
    check("s1_outrd", 32'(OutRd), 32'd5);
    check("s1_sticky", 32'(OvfSticky), 32'd1);
    check("s1_count", 32'(OvfCount), 32'd1);

    // Scenario 2: zero sum from 0xFFFF+1. The accept and pop occur together
    // at count 1.
    drive(16'h0000, 1'b0, 3'd2, 3'b100);
    tick();
    idle();
    check("s2_outvalid", 32'(OutValid), 32'd1);
    check("s2_result", 32'(Result), 32'h0000);
    check("s2_flags", 32'(Flags), 32'b100);
    check("s2_count", 32'(OvfCount), 32'd1);
    tick();
    check("s2_empty", 32'(OutValid), 32'd0);

    // Scenario 3: a stalled consumer, with three entries offered.
    OutReady = 1'b0;
    drive(16'h0002, 1'b0, 3'd1, 3'b000);
    tick();
    check("s3_inready_c1", 32'(InReady), 32'd1);
    drive(16'h0006, 1'b0, 3'd2, 3'b000);
    tick();
    check("s3_inready_full", 32'(InReady), 32'd0);
    drive(16'h8000, 1'b1, 3'd3, 3'b011);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("s3_stall_inready", 32'(InReady), 32'd0);
      check("s3_stall_result", 32'(Result), 32'h0002);
      check("s3_stall_outrd", 32'(OutRd), 32'd1);
    end
    check("s3_count_stalled", 32'(OvfCount), 32'd1);
    OutReady = 1'b1;
    tick();
    check("s3_head2", 32'(Result), 32'h0006);
    check("s3_inready_open", 32'(InReady), 32'd1);
    tick();
    idle();
    check("s3_head3", 32'(Result), 32'h8000);
    check("s3_flags3", 32'(Flags), 32'b011);
    tick();
    check("s3_drained", 32'(OutValid), 32'd0);
    check("s3_count", 32'(OvfCount), 32'd2);

    // Scenario 4: 300 V=1 entries saturate the counter at 255.
    for (int i = 0; i < 300; i++) begin
      drive(16'(16'h0100 + i), 1'b1, 3'(i), 3'b001);
      tick();
    end
    idle();
    tick();
    check("s4_sat_count", 32'(OvfCount), 32'd255);
    check("s4_sticky", 32'(OvfSticky), 32'd1);
    ClrSticky = 1'b1;
    tick();
    ClrSticky = 1'b0;
    check("s4_clr_count", 32'(OvfCount), 32'd0);
    check("s4_clr_sticky", 32'(OvfSticky), 32'd0);

    // Scenario 5: a clear coinciding with a V=1 accept. Then a clear on its
    // own while an entry is held.
    OutReady  = 1'b0;
    ClrSticky = 1'b1;
    drive(16'h8001, 1'b1, 3'd6, 3'b011);
    tick();
    ClrSticky = 1'b0;
    idle();
    check("s5_sticky", 32'(OvfSticky), 32'd1);
    check("s5_count", 32'(OvfCount), 32'd1);
    ClrSticky = 1'b1;
    tick();
    ClrSticky = 1'b0;
    check("s5_clr_count", 32'(OvfCount), 32'd0);
    check("s5_clr_sticky", 32'(OvfSticky), 32'd0);
    check("s5_hold_valid", 32'(OutValid), 32'd1);
    check("s5_hold_result", 32'(Result), 32'h8001);
    OutReady = 1'b1;
    tick();
    check("s5_drained", 32'(OutValid), 32'd0);

    // Scenario 6: reset applied while full.
    OutReady = 1'b0;
    drive(16'h1111, 1'b1, 3'd1, 3'b001);
    tick();
    drive(16'h2222, 1'b0, 3'd2, 3'b000);
    tick();
    idle();
    check("s6_full", 32'(InReady), 32'd0);
    check("s6_count_pre", 32'(OvfCount), 32'd1);
    #3;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("s6_rst_outvalid", 32'(OutValid), 32'd0);
    check("s6_rst_inready", 32'(InReady), 32'd1);
    check("s6_rst_result", 32'(Result), 32'd0);
    check("s6_rst_flags", 32'(Flags), 32'd0);
    check("s6_rst_outrd", 32'(OutRd), 32'd0);
    check("s6_rst_sticky", 32'(OvfSticky), 32'd0);
    check("s6_rst_count", 32'(OvfCount), 32'd0);
    tick();
    tick();
    rst_n    = 1'b1;
    OutReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("s6_no_stale", 32'(OutValid), 32'd0);
      check("s6_inready", 32'(InReady), 32'd1);
    end

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
